// File: rtl/ahb_sram_ctrl_pkg.sv
// Shared encodings for the AHB-to-SRAM controller: bus field codes and FSM state constants.
package ahb_sramc_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR      = 3'd1;
  localparam state_t ST_RD      = 3'd2;
  localparam state_t ST_RD_DATA = 3'd3;
  localparam state_t ST_ERR1    = 3'd4;
  localparam state_t ST_ERR2    = 3'd5;

  // Active-low chip selects for one bank; the other bank stays deselected.
  function automatic logic [7:0] bank_csn(input logic bank, input logic [3:0] lanes);
    return bank ? {~lanes, 4'hF} : {4'hF, ~lanes};
  endfunction

endpackage

// File: rtl/ahb_sram_ctrl_if.sv
// AHB slave-side bus bundle between a master/decoder and the SRAM controller.
interface ahb_sram_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hready;
  logic                  hready_resp;
  logic [1:0]            hresp;
  logic [DATA_WIDTH-1:0] hrdata;

  modport master (
    output hsel, htrans, hwrite, hsize, hburst, haddr, hwdata, hready,
    input  hready_resp, hresp, hrdata
  );

  modport slave (
    input  hsel, htrans, hwrite, hsize, hburst, haddr, hwdata, hready,
    output hready_resp, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_ctrl_lane_dec.sv
// Byte-lane decoder: turns transfer size and low address bits into a lane mask and error flag.
module ahb_lane_dec
  import ahb_sramc_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lsb,
  output logic [3:0] lane_mask,
  output logic       xfer_err
);

  // Lane selection and misalignment / oversize detection
  always_comb begin
    lane_mask = 4'b0000;
    xfer_err  = 1'b0;
    case (hsize)
      HSIZE_BYTE: begin
        lane_mask = 4'b0001 << addr_lsb;
      end
      HSIZE_HALF: begin
        lane_mask = addr_lsb[1] ? 4'b1100 : 4'b0011;
        xfer_err  = addr_lsb[0];
      end
      HSIZE_WORD: begin
        lane_mask = 4'b1111;
        xfer_err  = (addr_lsb != 2'b00);
      end
      default: begin
        lane_mask = 4'b0000;
        xfer_err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB slave driving two banks of four byte-wide synchronous SRAMs; zero-wait writes, one-wait reads.
module ahb_sram_ctrl
  import ahb_sramc_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 13,
  parameter int SRAM_DATA_WIDTH = 8
)(
  input  logic                       hclk,
  input  logic                       hresetn,
  ahb_sram_ctrl_if.slave             ahb,
  output logic [7:0]                 sram_csn,
  output logic                       sram_wen,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0]      sram_wdata,
  input  logic [2*DATA_WIDTH-1:0]    sram_q
);

  localparam int BANK_BIT = SRAM_ADDR_WIDTH + 2;

  state_t                     state_r;
  state_t                     state_nxt_s;
  logic                       bank_r;
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr_r;
  logic                       hready_resp_r;
  logic [1:0]                 hresp_r;
  logic [7:0]                 sram_csn_r;
  logic                       sram_wen_r;
  logic [7:0]                 csn_nxt_s;
  logic [3:0]                 lanes_s;
  logic [3:0]                 lane_mask_s;
  logic                       xfer_err_s;
  logic                       can_accept_s;
  logic                       accept_s;
  logic [DATA_WIDTH-1:0]      hrdata_s;

  ahb_lane_dec u_lane_dec (
    .hsize     (ahb.hsize),
    .addr_lsb  (ahb.haddr[1:0]),
    .lane_mask (lane_mask_s),
    .xfer_err  (xfer_err_s)
  );

  // The slave is stalling the bus in RD and ERR1, so no address phase can complete there
  assign can_accept_s = (state_r != ST_RD) && (state_r != ST_ERR1);
  assign accept_s     = can_accept_s && ahb.hsel && ahb.hready && ahb.htrans[1];

  // Next-state selection
  always_comb begin
    state_nxt_s = ST_IDLE;
    if (accept_s) begin
      if (xfer_err_s) begin
        state_nxt_s = ST_ERR1;
      end else if (ahb.hwrite) begin
        state_nxt_s = ST_WR;
      end else begin
        state_nxt_s = ST_RD;
      end
    end else begin
      case (state_r)
        ST_RD:   state_nxt_s = ST_RD_DATA;
        ST_ERR1: state_nxt_s = ST_ERR2;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Chip selects for the coming cycle; WR/RD are only entered on an accept, so haddr is current
  always_comb begin
    lanes_s = 4'b0000;
    case (state_nxt_s)
      ST_WR:   lanes_s = lane_mask_s;
      ST_RD:   lanes_s = 4'b1111;
      default: lanes_s = 4'b0000;
    endcase
    csn_nxt_s = bank_csn(ahb.haddr[BANK_BIT], lanes_s);
  end

  // State, captured address and registered bus/SRAM strobes
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_r       <= ST_IDLE;
      bank_r        <= 1'b0;
      sram_addr_r   <= {SRAM_ADDR_WIDTH{1'b0}};
      hready_resp_r <= 1'b1;
      hresp_r       <= HRESP_OKAY;
      sram_csn_r    <= 8'hFF;
      sram_wen_r    <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        bank_r      <= ahb.haddr[BANK_BIT];
        sram_addr_r <= ahb.haddr[SRAM_ADDR_WIDTH+1:2];
      end else begin
        bank_r      <= bank_r;
        sram_addr_r <= sram_addr_r;
      end
      hready_resp_r <= (state_nxt_s != ST_RD) && (state_nxt_s != ST_ERR1);
      hresp_r       <= ((state_nxt_s == ST_ERR1) || (state_nxt_s == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
      sram_csn_r    <= csn_nxt_s;
      sram_wen_r    <= (state_nxt_s != ST_WR);
    end
  end

  // Read data arrives from the chips one cycle after select, so it is steered combinationally
  always_comb begin
    hrdata_s = {DATA_WIDTH{1'b0}};
    if (state_r == ST_RD_DATA) begin
      hrdata_s = bank_r ? sram_q[DATA_WIDTH +: DATA_WIDTH] : sram_q[0 +: DATA_WIDTH];
    end else begin
      hrdata_s = {DATA_WIDTH{1'b0}};
    end
  end

  assign ahb.hready_resp = hready_resp_r;
  assign ahb.hresp       = hresp_r;
  assign ahb.hrdata      = hrdata_s;
  assign sram_csn        = sram_csn_r;
  assign sram_wen        = sram_wen_r;
  assign sram_addr       = sram_addr_r;
  assign sram_wdata      = ahb.hwdata;

endmodule
